// File: rtl/load_queue_pkg.sv
// Shared types, constants and load-result helpers for the load queue.
package load_queue_pkg;

  localparam int IQ_ADDR_W = 5;

  typedef logic [31:0]          addr_t;
  typedef logic [31:0]          word_t;
  typedef logic [2:0]           func3_t;
  typedef logic [IQ_ADDR_W-1:0] iq_addr_t;

  localparam addr_t MMIO_ADDR_DEF = 32'h0003_0000;

  typedef enum logic [1:0] {
    LQ_IDLE  = 2'd0,
    LQ_WAIT  = 2'd1,
    LQ_DRAIN = 2'd2
  } lq_state_e;

  // Memory-controller length code: 0 = byte, 1 = half, 3 = word.
  function automatic logic [1:0] mc_len(input func3_t f3);
    return (f3[1:0] == 2'd2) ? 2'd3 : f3[1:0];
  endfunction

  // func3[2] selects zero extension for sub-word loads.
  function automatic word_t load_extend(input func3_t f3, input word_t d);
    case (f3[1:0])
      2'd0:    return f3[2] ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'd1:    return f3[2] ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lq_fifo.sv
// Circular FIFO holding pending loads; pointers carry one extra wrap bit.
module lq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_head == r_tail);
  assign o_full    = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
                     (r_head[PTR_W-1] != r_tail[PTR_W-1]);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_head[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_clear) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      if (w_pop_ok)  r_head <= r_head + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clear) r_mem[r_tail[IDX_W-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/load_queue.sv
// Load queue: buffers loads from the reservation station, fetches them one at a
// time from the memory controller, and writes the extended result back to the IQ.
module load_queue
  import load_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          IQ_IDX_W  = IQ_ADDR_W,
  parameter logic [31:0] MMIO_ADDR = MMIO_ADDR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                update_stat,
  input  logic                clear_flag_in,
  input  logic                rs_load_enable_in,
  input  logic [2:0]          rs_func3_in,
  input  logic [31:0]         rs_addr_in,
  input  logic [IQ_IDX_W-1:0] rs_pos_in_iq_in,
  output logic                rs_full_out,
  output logic                mc_fetch_enable_out,
  output logic [31:0]         mc_addr_out,
  output logic [1:0]          mc_len_out,
  input  logic                mc_result_enable_in,
  input  logic [31:0]         mc_data_in,
  output logic                iq_write_enable_out,
  output logic [IQ_IDX_W-1:0] iq_write_idx_out,
  output logic [31:0]         iq_write_result_out,
  output logic                iq_write_ready_out,
  output logic                iq_write_need_cdb_out,
  output logic                iq_write_tar_addr_enable_out,
  output logic [31:0]         iq_write_tar_addr_out,
  output logic [1:0]          dbg_state_out
);

  localparam int ENT_W = 32 + 3 + IQ_IDX_W;

  lq_state_e           r_state;
  logic                r_fetch;
  logic [31:0]         r_mc_addr;
  logic [1:0]          r_mc_len;
  logic                r_we;
  logic [IQ_IDX_W-1:0] r_idx;
  logic [31:0]         r_result;
  logic                r_ready;
  logic                r_need_cdb;
  logic                r_tar_en;
  logic [31:0]         r_tar_addr;

  lq_state_e           w_state_nxt;
  logic                w_fetch_nxt;
  logic [31:0]         w_mc_addr_nxt;
  logic [1:0]          w_mc_len_nxt;
  logic                w_we_nxt;
  logic [IQ_IDX_W-1:0] w_idx_nxt;
  logic [31:0]         w_result_nxt;
  logic                w_ready_nxt;
  logic                w_need_cdb_nxt;
  logic                w_tar_en_nxt;
  logic [31:0]         w_tar_addr_nxt;

  logic                w_upd;
  logic                w_clr;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [ENT_W-1:0]    w_entry;
  logic [ENT_W-1:0]    w_head;
  logic [31:0]         w_head_addr;
  func3_t              w_head_func3;
  logic [IQ_IDX_W-1:0] w_head_idx;

  // Normal updates and flushes are mutually exclusive phases of an rdy cycle.
  assign w_upd  = rdy & update_stat;
  assign w_clr  = rdy & ~update_stat & clear_flag_in;
  assign w_push = w_upd & rs_load_enable_in & ~w_full;

  assign w_entry      = {rs_addr_in, rs_func3_in, rs_pos_in_iq_in};
  assign w_head_addr  = w_head[ENT_W-1 -: 32];
  assign w_head_func3 = w_head[IQ_IDX_W +: 3];
  assign w_head_idx   = w_head[IQ_IDX_W-1:0];

  lq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_fetch_nxt    = 1'b0;
    w_mc_addr_nxt  = r_mc_addr;
    w_mc_len_nxt   = r_mc_len;
    w_we_nxt       = 1'b0;
    w_idx_nxt      = r_idx;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;
    w_need_cdb_nxt = r_need_cdb;
    w_tar_en_nxt   = 1'b0;
    w_tar_addr_nxt = r_tar_addr;
    if (w_clr) begin
      // An in-flight fetch still returns data; DRAIN swallows it.
      if (r_state == LQ_WAIT) w_state_nxt = LQ_DRAIN;
    end else if (w_upd) begin
      case (r_state)
        LQ_IDLE: begin
          if (!w_empty) begin
            if (w_head_addr == MMIO_ADDR) begin
              w_pop          = 1'b1;
              w_we_nxt       = 1'b1;
              w_idx_nxt      = w_head_idx;
              w_result_nxt   = '0;
              w_ready_nxt    = 1'b0;
              w_need_cdb_nxt = 1'b0;
              w_tar_en_nxt   = 1'b1;
              w_tar_addr_nxt = MMIO_ADDR;
            end else begin
              w_fetch_nxt   = 1'b1;
              w_mc_addr_nxt = w_head_addr;
              w_mc_len_nxt  = mc_len(w_head_func3);
              w_state_nxt   = LQ_WAIT;
            end
          end
        end
        LQ_WAIT: begin
          if (mc_result_enable_in) begin
            w_pop          = 1'b1;
            w_we_nxt       = 1'b1;
            w_idx_nxt      = w_head_idx;
            w_result_nxt   = load_extend(w_head_func3, mc_data_in);
            w_ready_nxt    = 1'b1;
            w_need_cdb_nxt = 1'b1;
            w_state_nxt    = LQ_IDLE;
          end
        end
        LQ_DRAIN: begin
          if (mc_result_enable_in) w_state_nxt = LQ_IDLE;
        end
        default: w_state_nxt = LQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= LQ_IDLE;
      r_fetch    <= 1'b0;
      r_mc_addr  <= '0;
      r_mc_len   <= '0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_result   <= '0;
      r_ready    <= 1'b0;
      r_need_cdb <= 1'b0;
      r_tar_en   <= 1'b0;
      r_tar_addr <= '0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_fetch    <= w_fetch_nxt;
      r_mc_addr  <= w_mc_addr_nxt;
      r_mc_len   <= w_mc_len_nxt;
      r_we       <= w_we_nxt;
      r_idx      <= w_idx_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
      r_need_cdb <= w_need_cdb_nxt;
      r_tar_en   <= w_tar_en_nxt;
      r_tar_addr <= w_tar_addr_nxt;
    end
  end

  assign rs_full_out                  = w_full;
  assign mc_fetch_enable_out          = r_fetch;
  assign mc_addr_out                  = r_mc_addr;
  assign mc_len_out                   = r_mc_len;
  assign iq_write_enable_out          = r_we;
  assign iq_write_idx_out             = r_idx;
  assign iq_write_result_out          = r_result;
  assign iq_write_ready_out           = r_ready;
  assign iq_write_need_cdb_out        = r_need_cdb;
  assign iq_write_tar_addr_enable_out = r_tar_en;
  assign iq_write_tar_addr_out        = r_tar_addr;
  assign dbg_state_out                = r_state;

endmodule

// File: tb/tb_load_queue.sv
// Self-checking bench for load_queue: scoreboarded fetches and write-backs.
module tb_load_queue;

  localparam int DEPTH   = 4;
  localparam int IQW     = 5;
  localparam int WB_W    = IQW + 67;
  localparam int TIMEOUT = 200;

  // Clock / reset and DUT signals
  logic           clk = 1'b0;
  logic           rst;
  logic           rdy;
  logic           update_stat;
  logic           clear_flag_in;
  logic           rs_load_enable_in;
  logic [2:0]     rs_func3_in;
  logic [31:0]    rs_addr_in;
  logic [IQW-1:0] rs_pos_in_iq_in;
  logic           rs_full_out;
  logic           mc_fetch_enable_out;
  logic [31:0]    mc_addr_out;
  logic [1:0]     mc_len_out;
  logic           mc_result_enable_in;
  logic [31:0]    mc_data_in;
  logic           iq_write_enable_out;
  logic [IQW-1:0] iq_write_idx_out;
  logic [31:0]    iq_write_result_out;
  logic           iq_write_ready_out;
  logic           iq_write_need_cdb_out;
  logic           iq_write_tar_addr_enable_out;
  logic [31:0]    iq_write_tar_addr_out;
  logic [1:0]     dbg_state_out;

  int checks     = 0;
  int errors     = 0;
  int fetch_seen = 0;
  int served     = 0;
  int wb_seen    = 0;

  // Scoreboard: write-back {idx, result, ready, need_cdb, tar_en, tar_addr}; fetch {addr, len}
  logic [WB_W-1:0] exp_q[$];
  logic [33:0]     exp_fetch_q[$];

  always #5 clk = ~clk;

  load_queue #(
    .DEPTH     (DEPTH),
    .IQ_IDX_W  (IQW),
    .MMIO_ADDR (32'h0003_0000)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .rdy                          (rdy),
    .update_stat                  (update_stat),
    .clear_flag_in                (clear_flag_in),
    .rs_load_enable_in            (rs_load_enable_in),
    .rs_func3_in                  (rs_func3_in),
    .rs_addr_in                   (rs_addr_in),
    .rs_pos_in_iq_in              (rs_pos_in_iq_in),
    .rs_full_out                  (rs_full_out),
    .mc_fetch_enable_out          (mc_fetch_enable_out),
    .mc_addr_out                  (mc_addr_out),
    .mc_len_out                   (mc_len_out),
    .mc_result_enable_in          (mc_result_enable_in),
    .mc_data_in                   (mc_data_in),
    .iq_write_enable_out          (iq_write_enable_out),
    .iq_write_idx_out             (iq_write_idx_out),
    .iq_write_result_out          (iq_write_result_out),
    .iq_write_ready_out           (iq_write_ready_out),
    .iq_write_need_cdb_out        (iq_write_need_cdb_out),
    .iq_write_tar_addr_enable_out (iq_write_tar_addr_enable_out),
    .iq_write_tar_addr_out        (iq_write_tar_addr_out),
    .dbg_state_out                (dbg_state_out)
  );

  // Reference model
  function automatic logic [1:0] len_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 2'd0;
      3'b001, 3'b101: return 2'd1;
      default:        return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] ext_of(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [127:0] outs();
    return {rs_full_out, mc_fetch_enable_out, mc_addr_out, mc_len_out,
            iq_write_enable_out, iq_write_idx_out, iq_write_result_out,
            iq_write_ready_out, iq_write_need_cdb_out, iq_write_tar_addr_enable_out,
            iq_write_tar_addr_out, dbg_state_out};
  endfunction

  // Output monitor: a pulse is consumed at the next rdy-high edge
  logic [WB_W-1:0] mon_e;
  logic [WB_W-1:0] mon_g;
  logic [33:0]     mon_f;
  logic            mon_ok;
  always @(negedge clk) begin
    if (rst && rdy) begin
      if (mc_fetch_enable_out) begin
        fetch_seen++;
        checks++;
        if (exp_fetch_q.size() == 0) begin
          errors++;
          $display("FAIL fetch_unexpected got addr=%h len=%0d", mc_addr_out, mc_len_out);
        end else begin
          mon_f = exp_fetch_q.pop_front();
          if ({mc_addr_out, mc_len_out} !== mon_f) begin
            errors++;
            $display("FAIL fetch got addr=%h len=%0d exp addr=%h len=%0d",
                     mc_addr_out, mc_len_out, mon_f[33:2], mon_f[1:0]);
          end
        end
      end
      if (iq_write_enable_out) begin
        wb_seen++;
        checks++;
        mon_g = {iq_write_idx_out, iq_write_result_out, iq_write_ready_out,
                 iq_write_need_cdb_out, iq_write_tar_addr_enable_out, iq_write_tar_addr_out};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected got idx=%0d res=%h", iq_write_idx_out, iq_write_result_out);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_ok = (mon_g[WB_W-1:67] === mon_e[WB_W-1:67]) && (mon_g[34:32] === mon_e[34:32]) &&
                   (mon_e[32] ? (mon_g[31:0] === mon_e[31:0]) : (mon_g[66:35] === mon_e[66:35]));
          if (!mon_ok) begin
            errors++;
            $display("FAIL wb got idx=%0d res=%h rdy/cdb/tae=%b ta=%h exp idx=%0d res=%h rdy/cdb/tae=%b ta=%h",
                     mon_g[WB_W-1:67], mon_g[66:35], mon_g[34:32], mon_g[31:0],
                     mon_e[WB_W-1:67], mon_e[66:35], mon_e[34:32], mon_e[31:0]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy                 = 1'b1;
    update_stat         = 1'b1;
    clear_flag_in       = 1'b0;
    rs_load_enable_in   = 1'b0;
    rs_func3_in         = 3'b0;
    rs_addr_in          = 32'h0;
    rs_pos_in_iq_in     = '0;
    mc_result_enable_in = 1'b0;
    mc_data_in          = 32'h0;
  endtask

  task automatic enqueue(input logic [2:0] f3, input logic [31:0] addr, input logic [IQW-1:0] idx);
    rs_load_enable_in = 1'b1;
    rs_func3_in       = f3;
    rs_addr_in        = addr;
    rs_pos_in_iq_in   = idx;
    tick();
    rs_load_enable_in = 1'b0;
  endtask

  task automatic expect_load(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [IQW-1:0] idx, input logic [31:0] data);
    exp_fetch_q.push_back({addr, len_of(f3)});
    exp_q.push_back({idx, ext_of(f3, data), 1'b1, 1'b1, 1'b0, 32'h0});
  endtask

  task automatic wait_fetch(input int n);
    int t = 0;
    while (fetch_seen < n && t < TIMEOUT) begin
      tick();
      t++;
    end
    if (fetch_seen < n) begin
      errors++;
      $display("FAIL fetch_timeout got %0d fetches exp %0d", fetch_seen, n);
    end
  endtask

  task automatic serve(input logic [31:0] data, input int latency);
    wait_fetch(served + 1);
    repeat (latency) tick();
    mc_result_enable_in = 1'b1;
    mc_data_in          = data;
    tick();
    mc_result_enable_in = 1'b0;
    served++;
  endtask

  task automatic wait_wb(input int n);
    int t = 0;
    while (wb_seen < n && t < TIMEOUT) begin
      tick();
      t++;
    end
    if (wb_seen < n) begin
      errors++;
      $display("FAIL wb_timeout got %0d write-backs exp %0d", wb_seen, n);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    idle_inputs();
    rst                 = 1'b0;
    rs_load_enable_in   = 1'b1;
    rs_addr_in          = 32'h1234;
    mc_result_enable_in = 1'b1;
    repeat (3) tick();
    checks++;
    if (outs() !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", outs());
    end
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (outs() !== 128'h0) begin
      errors++;
      $display("FAIL post_reset_idle got %h exp 0", outs());
    end
  endtask

  task automatic test_lb_lbu();
    int n0 = wb_seen;
    exp_fetch_q.push_back({32'h100, 2'd0});
    exp_q.push_back({5'd1, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0, 32'h0});
    enqueue(3'b000, 32'h100, 5'd1);
    serve(32'h1234_5680, 2);
    wait_wb(n0 + 1);
    checks++;
    if (mc_addr_out !== 32'h100 || mc_len_out !== 2'd0) begin
      errors++;
      $display("FAIL lb_fetch_regs got addr=%h len=%0d exp addr=00000100 len=0", mc_addr_out, mc_len_out);
    end
    exp_fetch_q.push_back({32'h100, 2'd0});
    exp_q.push_back({5'd2, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 32'h0});
    enqueue(3'b100, 32'h100, 5'd2);
    serve(32'h1234_5680, 0);
    wait_wb(n0 + 2);
    checks++;
    if (iq_write_result_out !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_result got %h exp 00000080", iq_write_result_out);
    end
  endtask

  task automatic test_widths();
    logic [2:0] f3_tab [5] = '{3'b001, 3'b101, 3'b010, 3'b000, 3'b100};
    logic [31:0] d_tab [5] = '{32'hAAAA_8001, 32'h5555_8001, 32'hDEAD_BEEF, 32'h0000_007F, 32'hFFFF_FFFF};
    int n0 = wb_seen;
    for (int i = 0; i < 5; i++) begin
      expect_load(f3_tab[i], 32'h1000 + 32'(i * 4), IQW'(3 + i), d_tab[i]);
      enqueue(f3_tab[i], 32'h1000 + 32'(i * 4), IQW'(3 + i));
      serve(d_tab[i], $urandom_range(0, 3));
    end
    wait_wb(n0 + 5);
    checks++;
    if (wb_seen !== n0 + 5) begin
      errors++;
      $display("FAIL widths_count got %0d exp %0d", wb_seen, n0 + 5);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = wb_seen;
    for (int i = 0; i < DEPTH; i++) begin
      expect_load(3'b010, 32'h2000 + 32'(i * 4), IQW'(4 + i), 32'hC0DE_0000 + 32'(i));
      enqueue(3'b010, 32'h2000 + 32'(i * 4), IQW'(4 + i));
      if (i == DEPTH - 2) begin
        checks++;
        if (rs_full_out !== 1'b0) begin
          errors++;
          $display("FAIL b2b_not_full got %b exp 0", rs_full_out);
        end
      end
    end
    checks++;
    if (rs_full_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full got %b exp 1", rs_full_out);
    end
    enqueue(3'b010, 32'h2010, 5'd8);
    checks++;
    if (rs_full_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drop_full got %b exp 1", rs_full_out);
    end
    for (int i = 0; i < DEPTH; i++) serve(32'hC0DE_0000 + 32'(i), i);
    wait_wb(n0 + DEPTH);
    repeat (4) tick();
    checks++;
    if (rs_full_out !== 1'b0 || exp_q.size() != 0 || wb_seen !== n0 + DEPTH) begin
      errors++;
      $display("FAIL b2b_drain got full=%b pending=%0d wbs=%0d exp full=0 pending=0 wbs=%0d",
               rs_full_out, exp_q.size(), wb_seen - n0, DEPTH);
    end
  endtask

  task automatic test_mmio();
    int n0 = wb_seen;
    int f0 = fetch_seen;
    exp_q.push_back({5'd9, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0003_0000});
    enqueue(3'b010, 32'h0003_0000, 5'd9);
    wait_wb(n0 + 1);
    repeat (3) tick();
    checks++;
    if (fetch_seen !== f0 || wb_seen !== n0 + 1) begin
      errors++;
      $display("FAIL mmio_counts got fetches=%0d wbs=%0d exp fetches=0 wbs=1", fetch_seen - f0, wb_seen - n0);
    end
  endtask

  task automatic test_clear_wait();
    int n0 = wb_seen;
    int f0 = fetch_seen;
    exp_fetch_q.push_back({32'h200, 2'd3});
    enqueue(3'b010, 32'h200, 5'd10);
    enqueue(3'b010, 32'h204, 5'd11);
    wait_fetch(f0 + 1);
    update_stat   = 1'b0;
    clear_flag_in = 1'b1;
    tick();
    update_stat   = 1'b1;
    clear_flag_in = 1'b0;
    checks++;
    if (dbg_state_out !== 2'd2 || rs_full_out !== 1'b0) begin
      errors++;
      $display("FAIL clear_state got state=%0d full=%b exp state=2 full=0", dbg_state_out, rs_full_out);
    end
    expect_load(3'b001, 32'h400, 5'd13, 32'h0000_5A5A);
    enqueue(3'b001, 32'h400, 5'd13);
    repeat (3) tick();
    checks++;
    if (fetch_seen !== f0 + 1) begin
      errors++;
      $display("FAIL drain_no_fetch got %0d fetches exp %0d", fetch_seen - f0, 1);
    end
    mc_result_enable_in = 1'b1;
    mc_data_in          = 32'hDEAD_BEEF;
    tick();
    mc_result_enable_in = 1'b0;
    served++;
    checks++;
    if (wb_seen !== n0 || dbg_state_out !== 2'd0) begin
      errors++;
      $display("FAIL drain_discard got wbs=%0d state=%0d exp wbs=0 state=0", wb_seen - n0, dbg_state_out);
    end
    serve(32'h0000_5A5A, 1);
    wait_wb(n0 + 1);
    repeat (3) tick();
    checks++;
    if (wb_seen !== n0 + 1 || iq_write_result_out !== 32'h0000_5A5A) begin
      errors++;
      $display("FAIL after_clear got wbs=%0d res=%h exp wbs=1 res=00005a5a", wb_seen - n0, iq_write_result_out);
    end
  endtask

  task automatic test_simul_and_hold();
    logic [127:0] snap;
    int n0 = wb_seen;
    for (int i = 0; i < 3; i++) begin
      expect_load(3'b010, 32'h600 + 32'(i * 4), IQW'(16 + i), 32'hA000_0000 + 32'(i));
      enqueue(3'b010, 32'h600 + 32'(i * 4), IQW'(16 + i));
    end
    wait_fetch(served + 1);
    expect_load(3'b010, 32'h60C, 5'd19, 32'hA000_0003);
    rs_load_enable_in   = 1'b1;
    rs_func3_in         = 3'b010;
    rs_addr_in          = 32'h60C;
    rs_pos_in_iq_in     = 5'd19;
    mc_result_enable_in = 1'b1;
    mc_data_in          = 32'hA000_0000;
    tick();
    rs_load_enable_in   = 1'b0;
    mc_result_enable_in = 1'b0;
    served++;
    checks++;
    if (rs_full_out !== 1'b0) begin
      errors++;
      $display("FAIL simul_count3 got full=%b exp 0", rs_full_out);
    end
    expect_load(3'b010, 32'h610, 5'd20, 32'hA000_0004);
    enqueue(3'b010, 32'h610, 5'd20);
    checks++;
    if (rs_full_out !== 1'b1) begin
      errors++;
      $display("FAIL simul_then_full got full=%b exp 1", rs_full_out);
    end
    wait_fetch(served + 1);
    snap = outs();
    rdy  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mc_result_enable_in = 1'b1;
      mc_data_in          = $urandom;
      clear_flag_in       = c[0];
      update_stat         = ~c[0];
      rs_load_enable_in   = 1'b1;
      tick();
      checks++;
      if (outs() !== snap) begin
        errors++;
        $display("FAIL rdy_hold cycle %0d got %h exp %h", c, outs(), snap);
      end
    end
    idle_inputs();
    for (int i = 1; i < 5; i++) serve(32'hA000_0000 + 32'(i), $urandom_range(0, 2));
    wait_wb(n0 + 5);
    repeat (3) tick();
    checks++;
    if (wb_seen !== n0 + 5 || rs_full_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_loss got wbs=%0d full=%b exp wbs=5 full=0", wb_seen - n0, rs_full_out);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n0 = wb_seen;
    exp_fetch_q.push_back({32'h700, 2'd3});
    enqueue(3'b010, 32'h700, 5'd21);
    wait_fetch(served + 1);
    rst = 1'b0;
    #2;
    checks++;
    if (outs() !== 128'h0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", outs());
    end
    tick();
    rst    = 1'b1;
    served = fetch_seen;
    mc_result_enable_in = 1'b1;
    mc_data_in          = 32'h1111_2222;
    tick();
    mc_result_enable_in = 1'b0;
    repeat (3) tick();
    checks++;
    if (wb_seen !== n0 || dbg_state_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_abandon got wbs=%0d state=%0d exp wbs=0 state=0", wb_seen - n0, dbg_state_out);
    end
    expect_load(3'b000, 32'h800, 5'd22, 32'hFFFF_FF7F);
    enqueue(3'b000, 32'h800, 5'd22);
    serve(32'hFFFF_FF7F, 1);
    wait_wb(n0 + 1);
    checks++;
    if (iq_write_result_out !== 32'h0000_007F) begin
      errors++;
      $display("FAIL lb_positive got %h exp 0000007f", iq_write_result_out);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lb_lbu();
    test_widths();
    test_back_to_back();
    test_mmio();
    test_clear_wait();
    test_simul_and_hold();
    test_reset_mid_wait();
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0 || exp_fetch_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got wb=%0d fetch=%0d exp 0 0", exp_q.size(), exp_fetch_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
